// File: rtl/jtag_pkg.sv
// Shared constants, loader FSM state encoding and width helper for the JTAG memory loader.
package jtag_pkg;

  localparam int unsigned DefAddrW     = 10;
  localparam int unsigned DefWordBytes = 4;

  // Plain-vector state encoding keeps the FSM compatible with older tool flows.
  typedef logic [2:0] loader_state_t;

  localparam loader_state_t StIdle    = 3'd0;
  localparam loader_state_t StWaitReq = 3'd1;
  localparam loader_state_t StAckHold = 3'd2;
  localparam loader_state_t StWrite   = 3'd3;
  localparam loader_state_t StFlush   = 3'd4;
  localparam loader_state_t StDone    = 3'd5;

  // Byte counter must hold every byte of a full memory plus one spare bit.
  function automatic int unsigned cnt_width(input int unsigned addr_w,
                                            input int unsigned word_bytes);
    return addr_w + $clog2(word_bytes) + 1;
  endfunction

endpackage

// File: rtl/byte_packer.sv
// Little-endian byte packing register: byte 0 lands in bits 7:0, lane pointer advances per byte.
module byte_packer #(
  parameter int unsigned WORD_BYTES = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    clr_i,
  input  logic                    load_i,
  input  logic                    adv_i,
  input  logic [7:0]              data_i,
  output logic [8*WORD_BYTES-1:0] word_o,
  output logic                    complete_o,
  output logic                    partial_o
);

  localparam int unsigned LaneW = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
  localparam logic [LaneW-1:0] LastLane = LaneW'(WORD_BYTES - 1);

  logic [LaneW-1:0]        r_lane;
  logic [LaneW-1:0]        w_lane_d;
  logic [8*WORD_BYTES-1:0] r_word;
  logic [8*WORD_BYTES-1:0] w_word_d;

  // Next lane pointer and packed word; clear takes priority over load and advance.
  always_comb begin
    w_lane_d = r_lane;
    w_word_d = r_word;
    if (clr_i) begin
      w_lane_d = '0;
      w_word_d = '0;
    end else begin
      if (load_i) begin
        for (int i = 0; i < int'(WORD_BYTES); i++) begin
          if (r_lane == LaneW'(i)) w_word_d[8*i +: 8] = data_i;
        end
      end
      if (adv_i) w_lane_d = r_lane + LaneW'(1);
    end
  end

  // Lane pointer and packing register state.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_lane <= '0;
      r_word <= '0;
    end else begin
      r_lane <= w_lane_d;
      r_word <= w_word_d;
    end
  end

  assign word_o     = r_word;
  // complete: the lane just loaded is the top byte of the word.
  assign complete_o = (r_lane == LastLane);
  assign partial_o  = (r_lane != '0);

endmodule

// File: rtl/jtag_mem_loader.sv
// Accepts bytes from the JTAG receiver over a 4-phase handshake, packs them into memory words
// and writes them to sequential BRAM addresses, zero-padding the last partial word.
module jtag_mem_loader
  import jtag_pkg::*;
#(
  parameter int unsigned ADDR_W     = DefAddrW,
  parameter int unsigned WORD_BYTES = DefWordBytes
) (
  input  logic                                     clk_i,
  input  logic                                     rst_ni,
  input  logic                                     sel_i,
  input  logic                                     word_r_i,
  input  logic [7:0]                               data_i,
  output logic                                     ack_o,
  output logic                                     mem_we_o,
  output logic [ADDR_W-1:0]                        mem_addr_o,
  output logic [8*WORD_BYTES-1:0]                  mem_data_o,
  output logic                                     busy_o,
  output logic                                     done_o,
  output logic                                     full_o,
  output logic                                     overflow_o,
  output logic [cnt_width(ADDR_W, WORD_BYTES)-1:0] byte_cnt_o
);

  localparam int unsigned CntW  = cnt_width(ADDR_W, WORD_BYTES);
  localparam int unsigned DataW = 8 * WORD_BYTES;

  loader_state_t     r_state;
  loader_state_t     w_state_d;
  logic [ADDR_W-1:0] r_word_addr;
  logic [ADDR_W-1:0] w_word_addr_d;
  logic [CntW-1:0]   r_byte_cnt;
  logic [CntW-1:0]   w_byte_cnt_d;
  logic              r_full;
  logic              w_full_d;
  logic              r_overflow;
  logic              w_overflow_d;

  logic              r_ack;
  logic              r_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DataW-1:0]  r_mem_data;
  logic              r_busy;
  logic              r_done;
  logic              w_we_d;
  logic [ADDR_W-1:0] w_mem_addr_d;
  logic [DataW-1:0]  w_mem_data_d;

  logic              w_pk_clr;
  logic              w_pk_load;
  logic              w_pk_adv;
  logic [DataW-1:0]  w_pk_word;
  logic              w_pk_complete;
  logic              w_pk_partial;

  byte_packer #(
    .WORD_BYTES (WORD_BYTES)
  ) u_packer (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .clr_i      (w_pk_clr),
    .load_i     (w_pk_load),
    .adv_i      (w_pk_adv),
    .data_i     (data_i),
    .word_o     (w_pk_word),
    .complete_o (w_pk_complete),
    .partial_o  (w_pk_partial)
  );

  // Session FSM: handshake sequencing, address/byte counters and full/overflow flags.
  always_comb begin
    w_state_d     = r_state;
    w_word_addr_d = r_word_addr;
    w_byte_cnt_d  = r_byte_cnt;
    w_full_d      = r_full;
    w_overflow_d  = r_overflow;
    w_pk_clr      = 1'b0;
    w_pk_load     = 1'b0;
    w_pk_adv      = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (sel_i) begin
          w_pk_clr      = 1'b1;
          w_word_addr_d = '0;
          w_byte_cnt_d  = '0;
          w_full_d      = 1'b0;
          w_overflow_d  = 1'b0;
          w_state_d     = StWaitReq;
        end
      end
      StWaitReq: begin
        if (!sel_i) begin
          w_state_d = w_pk_partial ? StFlush : StDone;
        end else if (word_r_i && !r_full) begin
          w_pk_load = 1'b1;
          w_state_d = StAckHold;
        end else if (word_r_i) begin
          w_overflow_d = 1'b1;
        end
      end
      StAckHold: begin
        // A session ending mid-handshake still keeps the byte already latched.
        if (!word_r_i || !sel_i) begin
          if (r_byte_cnt != '1) w_byte_cnt_d = r_byte_cnt + CntW'(1);
          if (w_pk_complete) begin
            w_state_d = StWrite;
          end else begin
            w_pk_adv  = 1'b1;
            w_state_d = sel_i ? StWaitReq : StFlush;
          end
        end
      end
      StWrite, StFlush: begin
        w_pk_clr = 1'b1;
        // The last address is written once; the pointer never wraps.
        if (r_word_addr == '1) w_full_d = 1'b1;
        else                   w_word_addr_d = r_word_addr + ADDR_W'(1);
        w_state_d = (r_state == StWrite && sel_i) ? StWaitReq : StDone;
      end
      StDone: begin
        w_state_d = StIdle;
      end
      default: begin
        w_state_d = StIdle;
      end
    endcase
  end

  // Outputs are decoded from the next state so they register in step with the FSM.
  always_comb begin
    w_we_d       = (w_state_d == StWrite) || (w_state_d == StFlush);
    w_mem_addr_d = w_we_d ? r_word_addr : r_mem_addr;
    w_mem_data_d = w_we_d ? w_pk_word : '0;
  end

  // State, counters and registered outputs with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state     <= StIdle;
      r_word_addr <= '0;
      r_byte_cnt  <= '0;
      r_full      <= 1'b0;
      r_overflow  <= 1'b0;
      r_ack       <= 1'b0;
      r_we        <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_data  <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_word_addr <= w_word_addr_d;
      r_byte_cnt  <= w_byte_cnt_d;
      r_full      <= w_full_d;
      r_overflow  <= w_overflow_d;
      r_ack       <= (w_state_d == StAckHold);
      r_we        <= w_we_d;
      r_mem_addr  <= w_mem_addr_d;
      r_mem_data  <= w_mem_data_d;
      r_busy      <= (w_state_d != StIdle);
      r_done      <= (w_state_d == StDone);
    end
  end

  assign ack_o      = r_ack;
  assign mem_we_o   = r_we;
  assign mem_addr_o = r_mem_addr;
  assign mem_data_o = r_mem_data;
  assign busy_o     = r_busy;
  assign done_o     = r_done;
  assign full_o     = r_full;
  assign overflow_o = r_overflow;
  assign byte_cnt_o = r_byte_cnt;

endmodule

// File: tb/tb_jtag_mem_loader.sv
// Directed bench for jtag_mem_loader: default build plus a 4-word build for the full/overflow case.
module tb_jtag_mem_loader;

  logic        clk;
  logic        rst_n;
  logic        sel;
  logic        word_r;
  logic [7:0]  data;

  logic        ack, mem_we, busy, done, full, overflow;
  logic [9:0]  mem_addr;
  logic [31:0] mem_data;
  logic [12:0] byte_cnt;

  logic        ack_s, mem_we_s, busy_s, done_s, full_s, overflow_s;
  logic [1:0]  mem_addr_s;
  logic [31:0] mem_data_s;
  logic [4:0]  byte_cnt_s;

  int n_vec;
  int n_miss;

  logic [9:0]  log_addr[$];
  logic [31:0] log_data[$];
  logic [1:0]  slog_addr[$];
  logic [31:0] slog_data[$];

  jtag_mem_loader #(
    .ADDR_W     (10),
    .WORD_BYTES (4)
  ) u_dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .sel_i      (sel),
    .word_r_i   (word_r),
    .data_i     (data),
    .ack_o      (ack),
    .mem_we_o   (mem_we),
    .mem_addr_o (mem_addr),
    .mem_data_o (mem_data),
    .busy_o     (busy),
    .done_o     (done),
    .full_o     (full),
    .overflow_o (overflow),
    .byte_cnt_o (byte_cnt)
  );

  jtag_mem_loader #(
    .ADDR_W     (2),
    .WORD_BYTES (4)
  ) u_dut_small (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .sel_i      (sel),
    .word_r_i   (word_r),
    .data_i     (data),
    .ack_o      (ack_s),
    .mem_we_o   (mem_we_s),
    .mem_addr_o (mem_addr_s),
    .mem_data_o (mem_data_s),
    .busy_o     (busy_s),
    .done_o     (done_s),
    .full_o     (full_s),
    .overflow_o (overflow_s),
    .byte_cnt_o (byte_cnt_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every write pulse of both instances, sampled mid-cycle.
  always @(negedge clk) begin
    if (mem_we) begin
      log_addr.push_back(mem_addr);
      log_data.push_back(mem_data);
    end
    if (mem_we_s) begin
      slog_addr.push_back(mem_addr_s);
      slog_data.push_back(mem_data_s);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    log_addr.delete();
    log_data.delete();
    slog_addr.delete();
    slog_data.delete();
  endtask

  task automatic start_session();
    sel = 1'b1;
    cyc();
  endtask

  // One receiver handshake; acked reports whether the watched instance raised ack.
  task automatic send_byte(input logic [7:0] b, input bit use_small, output bit acked);
    acked  = 1'b0;
    data   = b;
    word_r = 1'b1;
    for (int i = 0; i < 8 && !acked; i++) begin
      cyc();
      acked = use_small ? ack_s : ack;
    end
    word_r = 1'b0;
    if (acked) begin
      for (int i = 0; i < 8; i++) begin
        cyc();
        if (!(use_small ? ack_s : ack)) break;
      end
    end
  endtask

  task automatic end_session(input bit use_small, output bit got_done);
    got_done = 1'b0;
    sel = 1'b0;
    for (int i = 0; i < 10 && !got_done; i++) begin
      cyc();
      got_done = use_small ? done_s : done;
    end
    repeat (3) cyc();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) cyc();
    if (ack !== 1'b0) begin $display("FAIL rst_ack: got %b expected 0", ack); n_miss++; end
    n_vec++;
    if (mem_we !== 1'b0) begin $display("FAIL rst_we: got %b expected 0", mem_we); n_miss++; end
    n_vec++;
    if (mem_addr !== 10'h0) begin $display("FAIL rst_addr: got %h expected 0", mem_addr); n_miss++; end
    n_vec++;
    if (mem_data !== 32'h0) begin $display("FAIL rst_data: got %h expected 0", mem_data); n_miss++; end
    n_vec++;
    if (busy !== 1'b0) begin $display("FAIL rst_busy: got %b expected 0", busy); n_miss++; end
    n_vec++;
    if (done !== 1'b0) begin $display("FAIL rst_done: got %b expected 0", done); n_miss++; end
    n_vec++;
    if (full !== 1'b0) begin $display("FAIL rst_full: got %b expected 0", full); n_miss++; end
    n_vec++;
    if (overflow !== 1'b0) begin $display("FAIL rst_ovf: got %b expected 0", overflow); n_miss++; end
    n_vec++;
    if (byte_cnt !== 13'h0) begin $display("FAIL rst_cnt: got %0d expected 0", byte_cnt); n_miss++; end
    n_vec++;
    rst_n = 1'b1;
    cyc();
  endtask

  task automatic test_two_words();
    bit acked;
    bit got_done;
    clear_logs();
    start_session();
    if (busy !== 1'b1) begin $display("FAIL tw_busy: got %b expected 1", busy); n_miss++; end
    n_vec++;
    for (int i = 1; i <= 8; i++) begin
      send_byte(8'(i), 1'b0, acked);
      if (acked !== 1'b1) begin $display("FAIL tw_ack byte %0d: got %b expected 1", i, acked); n_miss++; end
      n_vec++;
    end
    end_session(1'b0, got_done);
    if (got_done !== 1'b1) begin $display("FAIL tw_done: got %b expected 1", got_done); n_miss++; end
    n_vec++;
    if (log_addr.size() != 2) begin $display("FAIL tw_nwr: got %0d expected 2", log_addr.size()); n_miss++; end
    n_vec++;
    if (log_addr.size() >= 2) begin
      if (log_addr[0] !== 10'd0 || log_data[0] !== 32'h04030201) begin
        $display("FAIL tw_wr0: got %h/%h expected 000/04030201", log_addr[0], log_data[0]); n_miss++;
      end
      n_vec++;
      if (log_addr[1] !== 10'd1 || log_data[1] !== 32'h08070605) begin
        $display("FAIL tw_wr1: got %h/%h expected 001/08070605", log_addr[1], log_data[1]); n_miss++;
      end
      n_vec++;
    end
    if (byte_cnt !== 13'd8) begin $display("FAIL tw_cnt: got %0d expected 8", byte_cnt); n_miss++; end
    n_vec++;
    if (busy !== 1'b0) begin $display("FAIL tw_idle: got %b expected 0", busy); n_miss++; end
    n_vec++;
  endtask

  task automatic test_flush();
    bit acked;
    bit got_done;
    clear_logs();
    start_session();
    for (int i = 0; i < 6; i++) send_byte(8'hA0 + 8'(i), 1'b0, acked);
    end_session(1'b0, got_done);
    if (got_done !== 1'b1) begin $display("FAIL fl_done: got %b expected 1", got_done); n_miss++; end
    n_vec++;
    if (log_addr.size() != 2) begin $display("FAIL fl_nwr: got %0d expected 2", log_addr.size()); n_miss++; end
    n_vec++;
    if (log_addr.size() >= 2) begin
      if (log_addr[0] !== 10'd0 || log_data[0] !== 32'hA3A2A1A0) begin
        $display("FAIL fl_wr0: got %h/%h expected 000/a3a2a1a0", log_addr[0], log_data[0]); n_miss++;
      end
      n_vec++;
      if (log_addr[1] !== 10'd1 || log_data[1] !== 32'h0000A5A4) begin
        $display("FAIL fl_wr1: got %h/%h expected 001/0000a5a4", log_addr[1], log_data[1]); n_miss++;
      end
      n_vec++;
    end
    if (byte_cnt !== 13'd6) begin $display("FAIL fl_cnt: got %0d expected 6", byte_cnt); n_miss++; end
    n_vec++;
  endtask

  task automatic test_hold();
    bit got_done;
    clear_logs();
    start_session();
    data   = 8'h5A;
    word_r = 1'b1;
    if (ack !== 1'b0) begin $display("FAIL hd_pre: got %b expected 0", ack); n_miss++; end
    n_vec++;
    for (int i = 0; i < 5; i++) begin
      cyc();
      if (ack !== 1'b1) begin $display("FAIL hd_ack cycle %0d: got %b expected 1", i, ack); n_miss++; end
      n_vec++;
    end
    if (byte_cnt !== 13'd0) begin $display("FAIL hd_cnt_hold: got %0d expected 0", byte_cnt); n_miss++; end
    n_vec++;
    word_r = 1'b0;
    cyc();
    if (ack !== 1'b0) begin $display("FAIL hd_drop: got %b expected 0", ack); n_miss++; end
    n_vec++;
    if (byte_cnt !== 13'd1) begin $display("FAIL hd_cnt: got %0d expected 1", byte_cnt); n_miss++; end
    n_vec++;
    end_session(1'b0, got_done);
    if (log_data.size() != 1 || log_data[0] !== 32'h0000005A) begin
      $display("FAIL hd_wr: got %0d writes expected 1 write of 0000005a", log_data.size()); n_miss++;
    end
    n_vec++;
  endtask

  task automatic test_full();
    bit          acked;
    bit          got_done;
    logic [31:0] exp_s [4] = '{32'h13121110, 32'h17161514, 32'h1B1A1918, 32'h1F1E1D1C};
    clear_logs();
    start_session();
    for (int i = 0; i < 16; i++) begin
      send_byte(8'h10 + 8'(i), 1'b1, acked);
      if (acked !== 1'b1) begin $display("FAIL fu_ack byte %0d: got %b expected 1", i, acked); n_miss++; end
      n_vec++;
      if (i == 14) begin
        if (full_s !== 1'b0) begin $display("FAIL fu_early: got %b expected 0", full_s); n_miss++; end
        n_vec++;
      end
    end
    cyc();
    if (full_s !== 1'b1) begin $display("FAIL fu_full: got %b expected 1", full_s); n_miss++; end
    n_vec++;
    if (overflow_s !== 1'b0) begin $display("FAIL fu_ovf_pre: got %b expected 0", overflow_s); n_miss++; end
    n_vec++;
    send_byte(8'h20, 1'b1, acked);
    if (acked !== 1'b0) begin $display("FAIL fu_17th_ack: got %b expected 0", acked); n_miss++; end
    n_vec++;
    if (overflow_s !== 1'b1) begin $display("FAIL fu_ovf: got %b expected 1", overflow_s); n_miss++; end
    n_vec++;
    if (byte_cnt_s !== 5'd16) begin $display("FAIL fu_cnt: got %0d expected 16", byte_cnt_s); n_miss++; end
    n_vec++;
    end_session(1'b1, got_done);
    if (got_done !== 1'b1) begin $display("FAIL fu_done: got %b expected 1", got_done); n_miss++; end
    n_vec++;
    if (slog_addr.size() != 4) begin $display("FAIL fu_nwr: got %0d expected 4", slog_addr.size()); n_miss++; end
    n_vec++;
    for (int k = 0; k < 4 && k < slog_addr.size(); k++) begin
      if (slog_addr[k] !== 2'(k) || slog_data[k] !== exp_s[k]) begin
        $display("FAIL fu_wr%0d: got %h/%h expected %0d/%h", k, slog_addr[k], slog_data[k], k, exp_s[k]);
        n_miss++;
      end
      n_vec++;
    end
  endtask

  task automatic test_sel_drop();
    bit acked;
    clear_logs();
    start_session();
    send_byte(8'hC0, 1'b0, acked);
    send_byte(8'hC1, 1'b0, acked);
    data   = 8'hC2;
    word_r = 1'b1;
    cyc();
    if (ack !== 1'b1) begin $display("FAIL sd_ack: got %b expected 1", ack); n_miss++; end
    n_vec++;
    sel = 1'b0;
    cyc();
    if (ack !== 1'b0) begin $display("FAIL sd_ack_drop: got %b expected 0", ack); n_miss++; end
    n_vec++;
    if (byte_cnt !== 13'd3) begin $display("FAIL sd_cnt: got %0d expected 3", byte_cnt); n_miss++; end
    n_vec++;
    if (mem_we !== 1'b1 || mem_addr !== 10'd0 || mem_data !== 32'h00C2C1C0) begin
      $display("FAIL sd_flush: got we=%b %h/%h expected we=1 000/00c2c1c0", mem_we, mem_addr, mem_data);
      n_miss++;
    end
    n_vec++;
    word_r = 1'b0;
    cyc();
    if (done !== 1'b1) begin $display("FAIL sd_done: got %b expected 1", done); n_miss++; end
    n_vec++;
    if (mem_data !== 32'h0) begin $display("FAIL sd_data_idle: got %h expected 0", mem_data); n_miss++; end
    n_vec++;
    repeat (3) cyc();
    if (log_addr.size() != 1) begin $display("FAIL sd_nwr: got %0d expected 1", log_addr.size()); n_miss++; end
    n_vec++;
  endtask

  task automatic test_reset_mid();
    bit acked;
    clear_logs();
    start_session();
    send_byte(8'hD0, 1'b0, acked);
    send_byte(8'hD1, 1'b0, acked);
    data   = 8'hD2;
    word_r = 1'b1;
    cyc();
    if (ack !== 1'b1) begin $display("FAIL rm_ack: got %b expected 1", ack); n_miss++; end
    n_vec++;
    rst_n = 1'b0;
    cyc();
    if ({ack, mem_we, busy, done, full, overflow} !== 6'b0) begin
      $display("FAIL rm_flags: got %b expected 000000", {ack, mem_we, busy, done, full, overflow});
      n_miss++;
    end
    n_vec++;
    if (byte_cnt !== 13'd0) begin $display("FAIL rm_cnt: got %0d expected 0", byte_cnt); n_miss++; end
    n_vec++;
    if (mem_data !== 32'h0 || mem_addr !== 10'h0) begin
      $display("FAIL rm_bus: got %h/%h expected 000/00000000", mem_addr, mem_data); n_miss++;
    end
    n_vec++;
    word_r = 1'b0;
    sel    = 1'b0;
    repeat (3) cyc();
    rst_n = 1'b1;
    repeat (3) cyc();
    if (log_addr.size() != 0) begin $display("FAIL rm_nwr: got %0d expected 0", log_addr.size()); n_miss++; end
    n_vec++;
  endtask

  initial begin
    n_vec  = 0;
    n_miss = 0;
    rst_n  = 1'b0;
    sel    = 1'b0;
    word_r = 1'b0;
    data   = 8'h00;
    test_reset();
    test_two_words();
    test_flush();
    test_hold();
    test_full();
    test_sel_drop();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/jtag_mem_loader.md
Name: jtag_mem_loader

Overview:
- Sits between the `jtag` byte receiver and the single-port program BRAM.
- Consumes bytes over the receiver's 4-phase `word_r`/`ack` handshake and packs WORD_BYTES bytes little-endian into one memory word.
- Writes each completed word at an auto-incrementing address and zero-pads the trailing partial word when the session ends.
- Replaces ad-hoc handshake logic in the top level; exposes session status for LEDs and for the future target-release logic.

Parameters:
ADDR_W, 10, memory word-address width
WORD_BYTES, 4, bytes per memory word (power of two, >=1)

Ports:
clk_i  in  1  system clock
rst_ni  in  1  synchronous, active-low reset
sel_i  in  1  programming session active; synchronous to clk_i
word_r_i  in  1  receiver byte-ready request (4-phase)
data_i  in  8  receiver byte, stable while word_r_i=1
ack_o  out  1  handshake acknowledge to receiver
mem_we_o  out  1  BRAM write enable, one-cycle pulse
mem_addr_o  out  ADDR_W  BRAM word address
mem_data_o  out  8*WORD_BYTES  BRAM write data
busy_o  out  1  session in progress (state != IDLE)
done_o  out  1  one-cycle pulse at session end
full_o  out  1  last address written; no further bytes accepted
overflow_o  out  1  sticky: byte offered while full
byte_cnt_o  out  ADDR_W+log2(WORD_BYTES)+1  bytes accepted this session

Behaviour:
- All outputs are registered. With rst_ni=0 at a clock edge, every output is 0, the FSM enters IDLE, and the packing register and counters clear. Reset mid-session drops ack_o immediately and abandons the partial word without writing it.
- FSM states: IDLE, WAIT_REQ, ACK_HOLD, WRITE, FLUSH, DONE. State encoding and the byte lane index `lane` are internal.
- IDLE
  - If sel_i=1: clear `lane`, `word_addr`, byte_cnt_o, full_o and overflow_o, then go to WAIT_REQ.
  - byte_cnt_o holds its last value while in IDLE so it can be read back.
- WAIT_REQ
  - If sel_i=0: go to FLUSH when lane!=0, otherwise to DONE.
  - Else if word_r_i=1 and full_o=0: latch data_i into byte lane `lane` (byte 0 = bits 7:0), set ack_o=1, go to ACK_HOLD. Latency from word_r_i seen to ack_o=1 is 1 cycle.
  - Else if word_r_i=1 and full_o=1: set overflow_o=1, do not ack, stay in WAIT_REQ.
- ACK_HOLD
  - ack_o stays 1 until word_r_i=0 is seen. On that cycle: ack_o=0 and byte_cnt_o+1.
  - If lane==WORD_BYTES-1, go to WRITE; else lane+1 and go to WAIT_REQ.
  - If sel_i falls during ACK_HOLD: the byte counts as accepted, ack_o=0, lane+1, then FLUSH (or WRITE if the word is now complete; that WRITE then goes to DONE).
- WRITE
  - mem_we_o=1 for exactly one cycle, with mem_addr_o=word_addr and mem_data_o=packed word.
  - Then clear the packing register and set lane=0.
  - If word_addr is all ones, set full_o=1 and hold word_addr (no wrap); else word_addr+1.
  - Next state is WAIT_REQ, or DONE if sel_i=0.
- FLUSH: one write pulse as in WRITE; unused upper lanes are 0x00. Then go to DONE.
- DONE: done_o=1 for one cycle, then IDLE.
- mem_addr_o and mem_data_o are valid only while mem_we_o=1. Otherwise mem_addr_o holds its last value and mem_data_o=0. An upper-level mux gives read ownership to the reader whenever busy_o=0.
- byte_cnt_o saturates at its maximum. full_o blocks any wrap of word_addr.
- A WORD_BYTES=1 build degenerates to one write per byte with FLUSH unreachable.

Decomposition:
- Package `jtag_pkg`: loader state enum; default WORD_BYTES and ADDR_W constants; a function computing the byte-count width.
- Natural sub-module: `byte_packer`. It holds lane select, the lane write, clear, and the `complete` flag, and is instantiated once. The FSM, counters and handshake stay in `jtag_mem_loader`.

Test Plan:
- Session with 8 bytes 0x01..0x08, WORD_BYTES=4 -> two writes: addr0=0x04030201, addr1=0x08070605; done_o pulse; byte_cnt_o=8; no FLUSH write.
- Session with 6 bytes 0xA0..0xA5 -> addr0=0xA3A2A1A0, then flush addr1=0x0000A5A4; byte_cnt_o=6.
- word_r_i held high for 5 cycles -> ack_o rises 1 cycle after word_r_i and falls the cycle word_r_i=0 is seen; only one byte is counted.
- ADDR_W=2, 17 bytes -> 4 writes to addr 0..3; full_o=1 after the addr-3 write; 17th byte never acked; overflow_o=1; no write to addr 0.
- sel_i dropped while in ACK_HOLD on byte 3 -> byte counted, flush write of 3 bytes with upper lane 0, done_o pulse.
- rst_ni=0 during ACK_HOLD after 2 bytes -> next cycle all outputs 0; no memory write occurs.
